// File: rtl/keypad_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned KEY_W    = NUM_ROWS * NUM_COLS;

    localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1110;

    typedef logic [1:0] row_idx_t;

    // Width needed to hold a population count of a full key frame.
    localparam int unsigned POP_W = $clog2(KEY_W + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [KEY_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic at_most_one(input logic [KEY_W-1:0] v);
        return popcount(v) <= POP_W'(1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a frame commits once it has been seen DEBOUNCE_SCANS
// consecutive times and holds at most one pressed key.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] frame,
    input  logic             frame_done,
    output logic             commit
);

    localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [KEY_W-1:0] r_last_frame;
    logic [CNT_W-1:0] r_stable_cnt;
    logic             w_single;
    logic [CNT_W-1:0] w_cnt_next;

    // A changed frame is the first of a run, so it commits only when one frame suffices.
    always_comb begin
        w_single = at_most_one(frame);
        if (!w_single || (frame != r_last_frame)) begin
            w_cnt_next = '0;
        end else if (r_stable_cnt == CNT_MAX) begin
            w_cnt_next = CNT_MAX;
        end else begin
            w_cnt_next = r_stable_cnt + CNT_W'(1);
        end
        commit = frame_done && w_single && (w_cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_frame <= '0;
            r_stable_cnt <= '0;
        end else if (frame_done) begin
            r_last_frame <= frame;
            r_stable_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner producing a held one-hot key code.
// Define KEYPAD_DEBOUNCE_EN to require repeated identical frames before commit.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col,
    output logic [NUM_ROWS-1:0] row,
    output logic [KEY_W-1:0]    onehot,
    output logic                valid
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 3 || DEBOUNCE_SCANS < 1) begin : g_bad_param
        $error("keypad_scan: CLK_DIV must be >= 3 and DEBOUNCE_SCANS >= 1");
    end

    logic [NUM_COLS-1:0] r_col_s1;
    logic [NUM_COLS-1:0] r_col_s2;
    logic [DIV_W-1:0]    r_div;
    row_idx_t            r_row_idx;
    logic [NUM_ROWS-1:0] r_row;
    logic [KEY_W-1:0]    r_frame;
    logic [KEY_W-1:0]    r_onehot;
    logic                r_valid;

    logic                w_tick;
    logic                w_frame_done;
    logic                w_commit;
    logic [KEY_W-1:0]    w_frame;

    // w_frame already contains the row being sampled this tick, so a completed
    // frame is judged on the same clock as its last row sample.
    always_comb begin
        w_tick       = (r_div == DIV_W'(CLK_DIV - 1));
        w_frame_done = w_tick && (r_row_idx == row_idx_t'(NUM_ROWS - 1));
        w_frame      = r_frame;
        w_frame[NUM_COLS*r_row_idx +: NUM_COLS] = ~r_col_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_row_idx <= '0;
            r_row     <= ROW_IDLE;
            r_frame   <= '0;
        end else if (w_tick) begin
            r_div     <= '0;
            r_row_idx <= r_row_idx + row_idx_t'(1);
            r_row     <= {r_row[NUM_ROWS-2:0], r_row[NUM_ROWS-1]};
            r_frame   <= w_frame;
        end else begin
            r_div     <= r_div + DIV_W'(1);
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame      (w_frame),
        .frame_done (w_frame_done),
        .commit     (w_commit)
    );
`else
    assign w_commit = w_frame_done && at_most_one(w_frame);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_commit && (w_frame != r_onehot)) begin
                r_onehot <= w_frame;
                r_valid  <= 1'b1;
            end
        end
    end

    assign row    = r_row;
    assign onehot = r_onehot;
    assign valid  = r_valid;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: physical key-matrix model drives col,
// a frame-level reference model predicts row/onehot/valid every cycle.
`timescale 1ns/1ps
module tb_keypad_scan;

    localparam int unsigned D  = 4;
    localparam int unsigned DS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] onehot;
    logic        valid;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    keypad_scan #(
        .CLK_DIV        (D),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .col    (col),
        .row    (row),
        .onehot (onehot),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge count since reset, key history, frame run length.
    int unsigned m_k;
    int unsigned m_run;
    int unsigned m_r;
    logic [15:0] m_hist [3];
    logic [15:0] m_frame;
    logic [15:0] m_last;
    logic [15:0] m_onehot;
    logic        m_valid;
    logic        m_ok;

    function automatic logic [3:0] m_row(input int unsigned k);
        return ~(4'b0001 << ((k / D) % 4));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0; m_run = 1;
            m_hist[0] = '0; m_hist[1] = '0; m_hist[2] = '0;
            m_frame = '0; m_last = '0; m_onehot = '0; m_valid = 1'b0;
        end else begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = keys;
            m_valid = 1'b0;
            if (m_k % D == D - 1) begin
                m_r = (m_k / D) % 4;
                m_frame[4*m_r +: 4] = m_hist[2][4*m_r +: 4];
                if (m_r == 3) begin
                    if (m_frame == m_last) begin
                        if (m_run < 1000) m_run++;
                    end else begin
                        m_run = 1;
                    end
                    m_last = m_frame;
`ifdef KEYPAD_DEBOUNCE_EN
                    m_ok = ($countones(m_frame) <= 1) && (m_run >= DS);
`else
                    m_ok = ($countones(m_frame) <= 1);
`endif
                    if (m_ok && m_frame != m_onehot) begin
                        m_onehot = m_frame;
                        m_valid  = 1'b1;
                    end
                end
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        check("row", {12'h0, row}, {12'h0, m_row(m_k)});
        check("onehot", onehot, m_onehot);
        check("valid", {15'h0, valid}, {15'h0, m_valid});
        if (valid === 1'b1) vcount++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns just after the row wraps 0111 -> 1110 so key changes land on frame boundaries.
    task automatic align_frame();
        logic [3:0] prev;
        prev = row;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #2;
            if (prev == 4'b0111 && row == 4'b1110) return;
            prev = row;
        end
        checks++; errors++;
        $display("FAIL align_timeout: row=%b never wrapped to 1110", row);
    endtask

    task automatic wait_row(input logic [3:0] target);
        for (int i = 0; i < 64; i++) begin
            if (row == target) return;
            @(posedge clk); #2;
        end
        checks++; errors++;
        $display("FAIL row_timeout: row=%b never reached %b", row, target);
    endtask

    logic [3:0] seq [4];

    initial begin
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        rst = 1'b1; keys = '0;
        cycles(3);
        check("reset_row", {12'h0, row}, 16'h000e);
        check("reset_onehot", onehot, 16'h0000);
        check("reset_valid", {15'h0, valid}, 16'h0000);

        // Scan sequence with no keys
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cycles(1);
            check("scan_row", {12'h0, row}, {12'h0, seq[(n / D) % 4]});
        end
        check("scan_onehot", onehot, 16'h0000);
        check("scan_pulses", 16'(vcount), 16'd0);

        // Single key: row 1, col 2
        vcount = 0;
        keys = 16'h0040;
        cycles(6 * 4 * D);
        check("single_onehot", onehot, 16'h0040);
        check("single_pulses", 16'(vcount), 16'd1);

        align_frame();
        vcount = 0;
        keys = 16'h0000;
        cycles(6 * 4 * D);
        check("release1_onehot", onehot, 16'h0000);
        check("release1_pulses", 16'(vcount), 16'd1);

        // Bounce: toggle every 6 clocks for 48 clocks
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            keys = keys ^ 16'h0040;
            cycles(6);
        end
`ifdef KEYPAD_DEBOUNCE_EN
        check("bounce_onehot", onehot, 16'h0000);
        check("bounce_pulses", 16'(vcount), 16'd0);
`endif
        keys = 16'h0040;
        cycles(6 * 4 * D);
        check("bounce_hold_onehot", onehot, 16'h0040);

        // Simultaneous keys are ignored
        align_frame();
        vcount = 0;
        keys = 16'h8041;
        cycles(6 * 4 * D);
        check("simul_onehot", onehot, 16'h0040);
        check("simul_pulses", 16'(vcount), 16'd0);

        align_frame();
        vcount = 0;
        keys = 16'h0000;
        cycles(6 * 4 * D);
        check("release_onehot", onehot, 16'h0000);
        check("release_pulses", 16'(vcount), 16'd1);

        // Mid-operation reset
        keys = 16'h0040;
        cycles(6 * 4 * D);
        wait_row(4'b1011);
        check("prereset_onehot", onehot, 16'h0040);
        rst = 1'b1;
        #1;
        check("async_row", {12'h0, row}, 16'h000e);
        check("async_onehot", onehot, 16'h0000);
        check("async_valid", {15'h0, valid}, 16'h0000);
        cycles(2);
        rst = 1'b0;
        cycles(D);
        check("restart_row", {12'h0, row}, 16'h000d);
        cycles(6 * 4 * D);
        check("restart_onehot", onehot, 16'h0040);

        // Randomized key patterns, with occasional resets
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: keys = '0;
                1: keys = 16'h0001 << $urandom_range(0, 15);
                2: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 2));
                rst = 1'b0;
            end
            cycles($urandom_range(1, 60));
        end
        keys = '0;
        cycles(6 * 4 * D);
        check("final_onehot", onehot, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
